fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_unit_pc_reg.sv | 35 +++
 rtl/fetch_unit.sv | 111 +++++++++++
 tb/tb_fetch_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    HALT = 3'd4
  } fetch_state_e;

  function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register with load enable and a sticky word-alignment error.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic [XLEN-1:0] pc_next_i,
  output logic [XLEN-1:0] pc_o,
  output logic            next_misaligned_o,
  output logic            misalign_err_o
);

  logic [XLEN-1:0] pc_q;
  logic            misalign_err_q;

  assign next_misaligned_o = is_misaligned(pc_next_i);

  // The misaligned value is still loaded so imem_addr shows what went wrong.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q           <= RESET_PC;
      misalign_err_q <= 1'b0;
    end else if (load_i) begin
      pc_q           <= pc_next_i;
      misalign_err_q <= misalign_err_q | next_misaligned_o;
    end
  end

  assign pc_o           = pc_q;
  assign misalign_err_o = misalign_err_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for data, hold for decode.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc_next,
  input  logic            flush,
  input  logic            stall,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign_err
);

  fetch_state_e    state_q;
  logic            instr_valid_q;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            drop_q;

  logic [XLEN-1:0] pc;
  logic            pc_load;
  logic            next_bad;
  logic            flush_active;
  logic            accept;

  assign flush_active = flush && (state_q == REQ || state_q == WAIT || state_q == HOLD);
  assign accept       = (state_q == HOLD) && instr_valid_q && !stall;
  assign pc_load      = flush_active || accept;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk               (clk),
    .rst_n             (rst_n),
    .load_i            (pc_load),
    .pc_next_i         (pc_next),
    .pc_o              (pc),
    .next_misaligned_o (next_bad),
    .misalign_err_o    (misalign_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      instr_valid_q <= 1'b0;
      instr_q       <= NOP_INSTR;
      instr_pc_q    <= '0;
      drop_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: state_q <= REQ;

        REQ: begin
          if (flush) begin
            state_q <= next_bad ? HALT : REQ;
          end else if (imem_req_ready) begin
            state_q <= WAIT;
          end
        end

        WAIT: begin
          if (flush) begin
            // A response arriving with the flush is the one being cancelled;
            // otherwise the next one still owes us a pulse and must be dropped.
            drop_q  <= !imem_rsp_valid && !next_bad;
            state_q <= next_bad ? HALT : (imem_rsp_valid ? REQ : WAIT);
          end else if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_q  <= 1'b0;
              state_q <= REQ;
            end else begin
              instr_q       <= imem_rsp_data;
              instr_pc_q    <= pc;
              instr_valid_q <= 1'b1;
              state_q       <= HOLD;
            end
          end
        end

        HOLD: begin
          if (flush || !stall) begin
            instr_valid_q <= 1'b0;
            state_q       <= next_bad ? HALT : REQ;
          end
        end

        HALT: state_q <= HALT;

        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem_req_valid = (state_q == REQ);
  assign imem_addr      = pc;
  assign instr_valid    = instr_valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign pc_plus4       = pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small instruction-memory responder.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_next;
  logic        flush;
  logic        stall;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Responder state: one outstanding request, answered after rsp_delay extra cycles.
  logic        pend;
  int          pend_cnt;
  logic [31:0] pend_addr;
  int          rsp_delay;
  int          hs_count;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pc_next        (pc_next),
    .flush          (flush),
    .stall          (stall),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_plus4       (pc_plus4),
    .misalign_err   (misalign_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0010_0093;
      32'h0000_0004: return 32'h0030_0113;
      32'h0000_0008: return 32'h0050_0093;
      32'h0000_0100: return 32'h00a0_0193;
      default:       return 32'h0000_006f;
    endcase
  endfunction

  // Advance one clock; inputs are updated 1 time unit after the rising edge.
  task automatic step();
    if (imem_req_valid && imem_req_ready) begin
      pend      = 1'b1;
      pend_cnt  = rsp_delay;
      pend_addr = imem_addr;
      hs_count  = hs_count + 1;
    end
    @(posedge clk);
    #1;
    if (pend && pend_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend_addr);
      pend           = 1'b0;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      if (pend) pend_cnt = pend_cnt - 1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0; stall = 1'b0; imem_req_ready = 1'b0; pc_next = 32'h0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0; rsp_delay = 0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  // From REQ with zero-latency memory: one full fetch, then accept with nxt.
  task automatic run_fetch(input logic [31:0] nxt);
    imem_req_ready = 1'b1;
    step(); step();
    $display("fetch: pc=%h instr=%h valid=%b", instr_pc, instr, instr_valid);
    pc_next = nxt;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0; stall = 1'b0; imem_req_ready = 1'b1; pc_next = 32'h40;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    pend = 1'b0; pend_cnt = 0; pend_addr = 32'h0; rsp_delay = 0; hs_count = 0;
    step(); step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_instr_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0000_0013) begin n_bad++; $display("FAIL reset_instr: got %h want 00000013", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL reset_instr_pc: got %h want 00000000", instr_pc); end
    n_cmp++; if (misalign_err !== 1'b0) begin n_bad++; $display("FAIL reset_misalign: got %b want 0", misalign_err); end
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_addr: got %h want 00000000", imem_addr); end
    n_cmp++; if (pc_plus4 !== 32'h4) begin n_bad++; $display("FAIL reset_pc_plus4: got %h want 00000004", pc_plus4); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL release_idle: got %b want 0", imem_req_valid); end
    imem_req_ready = 1'b0;
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL first_req: got valid=%b addr=%h want 1/00000000", imem_req_valid, imem_addr); end
  endtask

  task automatic test_basic_loop();
    logic [31:0] exp_instr [3];
    logic [31:0] a;
    exp_instr[0] = 32'h0010_0093;
    exp_instr[1] = 32'h0030_0113;
    exp_instr[2] = 32'h0050_0093;
    do_reset();
    imem_req_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a = 32'(4 * k);
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== a) begin n_bad++; $display("FAIL loop_req%0d: got valid=%b addr=%h want 1/%h", k, imem_req_valid, imem_addr, a); end
      step();
      n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL loop_wait%0d: got req=%b iv=%b want 0/0", k, imem_req_valid, instr_valid); end
      step();
      $display("fetch: pc=%h instr=%h valid=%b", instr_pc, instr, instr_valid);
      n_cmp++; if (instr_valid !== 1'b1 || instr !== exp_instr[k] || instr_pc !== a) begin n_bad++; $display("FAIL loop_hold%0d: got iv=%b instr=%h pc=%h want 1/%h/%h", k, instr_valid, instr, instr_pc, exp_instr[k], a); end
      n_cmp++; if (pc_plus4 !== a + 32'd4) begin n_bad++; $display("FAIL loop_pc_plus4_%0d: got %h want %h", k, pc_plus4, a + 32'd4); end
      pc_next = a + 32'd4;
      step();
    end
    n_cmp++; if (imem_addr !== 32'hC || instr_valid !== 1'b0) begin n_bad++; $display("FAIL loop_end: got addr=%h iv=%b want 0000000c/0", imem_addr, instr_valid); end
  endtask

  task automatic test_ready_backpressure();
    int hs0;
    do_reset();
    run_fetch(32'h4);
    imem_req_ready = 1'b0;
    hs0 = hs_count;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin n_bad++; $display("FAIL bp_hold%0d: got valid=%b addr=%h want 1/00000004", i, imem_req_valid, imem_addr); end
    end
    imem_req_ready = 1'b1;
    step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL bp_withdraw: got %b want 0", imem_req_valid); end
    step();
    n_cmp++; if (hs_count - hs0 !== 1) begin n_bad++; $display("FAIL bp_once: got %0d requests want 1", hs_count - hs0); end
    n_cmp++; if (instr_pc !== 32'h4 || instr !== 32'h0030_0113) begin n_bad++; $display("FAIL bp_data: got pc=%h instr=%h want 00000004/00300113", instr_pc, instr); end
  endtask

  task automatic test_stall();
    do_reset();
    run_fetch(32'h4);
    run_fetch(32'h8);
    imem_req_ready = 1'b1;
    step(); step();
    stall = 1'b1;
    pc_next = 32'hC;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h0050_0093 || instr_pc !== 32'h8 || pc_plus4 !== 32'hC) begin n_bad++; $display("FAIL stall%0d: got iv=%b instr=%h pc=%h p4=%h want 1/00500093/00000008/0000000c", i, instr_valid, instr, instr_pc, pc_plus4); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hC || instr_valid !== 1'b0) begin n_bad++; $display("FAIL stall_release: got req=%b addr=%h iv=%b want 1/0000000c/0", imem_req_valid, imem_addr, instr_valid); end
  endtask

  task automatic test_flush();
    do_reset();
    rsp_delay = 2;
    imem_req_ready = 1'b1;
    step();
    flush = 1'b1; pc_next = 32'h100;
    step();
    flush = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b0 || pc_plus4 !== 32'h104) begin n_bad++; $display("FAIL flush_wait: got req=%b p4=%h want 0/00000104", imem_req_valid, pc_plus4); end
    step();
    n_cmp++; if (imem_rsp_valid !== 1'b1 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL flush_late_rsp: got rsp=%b req=%b want 1/0", imem_rsp_valid, imem_req_valid); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0 || instr !== 32'h0000_0013) begin n_bad++; $display("FAIL flush_drop: got req=%b addr=%h iv=%b instr=%h want 1/00000100/0/00000013", imem_req_valid, imem_addr, instr_valid, instr); end
    rsp_delay = 0;
    step(); step();
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h00a0_0193 || instr_pc !== 32'h100) begin n_bad++; $display("FAIL flush_refetch: got iv=%b instr=%h pc=%h want 1/00a00193/00000100", instr_valid, instr, instr_pc); end
    // Flush coincident with the response: that response is discarded, no stale drop.
    pc_next = 32'h200;
    step();
    step();
    flush = 1'b1; pc_next = 32'h300;
    step();
    flush = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h300 || instr_valid !== 1'b0 || instr_pc !== 32'h100) begin n_bad++; $display("FAIL flush_coincident: got req=%b addr=%h iv=%b pc=%h want 1/00000300/0/00000100", imem_req_valid, imem_addr, instr_valid, instr_pc); end
    step(); step();
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h0000_006f || instr_pc !== 32'h300) begin n_bad++; $display("FAIL flush_no_stale_drop: got iv=%b instr=%h pc=%h want 1/0000006f/00000300", instr_valid, instr, instr_pc); end
    // Flush beats stall in HOLD; also exercises pc_plus4 wraparound.
    stall = 1'b1; flush = 1'b1; pc_next = 32'hFFFF_FFFC;
    step();
    stall = 1'b0; flush = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC || instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_over_stall: got req=%b addr=%h iv=%b want 1/fffffffc/0", imem_req_valid, imem_addr, instr_valid); end
    n_cmp++; if (pc_plus4 !== 32'h0 || misalign_err !== 1'b0) begin n_bad++; $display("FAIL pc_plus4_wrap: got p4=%h err=%b want 00000000/0", pc_plus4, misalign_err); end
  endtask

  task automatic test_misalign();
    int reqs;
    do_reset();
    imem_req_ready = 1'b1;
    step(); step();
    pc_next = 32'h102;
    step();
    n_cmp++; if (misalign_err !== 1'b1 || imem_req_valid !== 1'b0) begin n_bad++; $display("FAIL misalign_set: got err=%b req=%b want 1/0", misalign_err, imem_req_valid); end
    reqs = 0;
    flush = 1'b1; pc_next = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (imem_req_valid) reqs++;
    end
    flush = 1'b0;
    n_cmp++; if (reqs !== 0 || misalign_err !== 1'b1) begin n_bad++; $display("FAIL misalign_halt: got reqs=%0d err=%b want 0/1", reqs, misalign_err); end
    do_reset();
    n_cmp++; if (misalign_err !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL misalign_reset: got err=%b req=%b addr=%h want 0/1/00000000", misalign_err, imem_req_valid, imem_addr); end
  endtask

  task automatic test_reset_in_wait();
    do_reset();
    rsp_delay = 1;
    imem_req_ready = 1'b1;
    pc_next = 32'h40;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_async: got req=%b iv=%b want 0/0", imem_req_valid, instr_valid); end
    step();
    step();
    rst_n = 1'b1;
    step();
    n_cmp++; if (instr_valid !== 1'b0 || instr !== 32'h0000_0013 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_bad++; $display("FAIL rst_late_rsp: got iv=%b instr=%h req=%b addr=%h want 0/00000013/1/00000000", instr_valid, instr, imem_req_valid, imem_addr); end
    rsp_delay = 0;
    imem_req_ready = 1'b1;
    step(); step();
    n_cmp++; if (instr_valid !== 1'b1 || instr !== 32'h0010_0093 || instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_restart: got iv=%b instr=%h pc=%h want 1/00100093/00000000", instr_valid, instr, instr_pc); end
  endtask

  initial begin
    test_reset();
    test_basic_loop();
    test_ready_backpressure();
    test_stall();
    test_flush();
    test_misalign();
    test_reset_in_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
